valu_issue_ctrl: RTL



---
 rtl/valu_issue_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/valu_issue_ctrl.sv
// VALU issue queue: holds VALU ops until the shared FLU writeback port is free.
// Optional perf counters are compiled in with `define VALU_ISSUE_PERF_EN.
module valu_issue_ctrl #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned STARVE_LIMIT  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_operand_a_i,
    input  logic [31:0]              issue_operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
    input  logic                     flu_port_busy_i,
    input  logic                     valu_ready_i,
    output logic                     valu_valid_o,
    output logic [31:0]              valu_operand_a_o,
    output logic [31:0]              valu_operand_b_o,
    output logic [TRANS_ID_BITS-1:0] valu_trans_id_o,
    output logic                     flu_hold_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef VALU_ISSUE_PERF_EN
    ,
    output logic [31:0]              perf_fire_cnt_o,
    output logic [31:0]              perf_block_cnt_o,
    output logic [31:0]              perf_hold_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [31:0]              a;
        logic [31:0]              b;
        logic [TRANS_ID_BITS-1:0] id;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    state_e        state_q;
    state_e        state_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic [SW-1:0] starve_inc;
    logic          nonempty;
    logic          push;
    logic          fire;

    assign nonempty      = (count_q != '0);
    assign issue_ready_o = (count_q < FULL) & ~flush_i;
    assign push          = issue_valid_i & issue_ready_o;
    assign fire          = nonempty & ~flu_port_busy_i
                         & valu_ready_i & ~flush_i;

    assign wr_entry.a  = issue_operand_a_i;
    assign wr_entry.b  = issue_operand_b_i;
    assign wr_entry.id = issue_trans_id_i;

    assign head             = mem_q[rd_ptr_q];
    assign valu_valid_o     = fire;
    assign valu_operand_a_o = nonempty ? head.a  : '0;
    assign valu_operand_b_o = nonempty ? head.b  : '0;
    assign valu_trans_id_o  = nonempty ? head.id : '0;
    assign count_o          = count_q;

    // Payload storage; validity is tracked by count/pointers only.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (fire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign starve_inc = (starve_q == LIMIT) ? starve_q
                                            : starve_q + SW'(1);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (flush_i) begin
            state_d  = IDLE;
            starve_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (nonempty && !fire) begin
                        starve_d = SW'(1);
                        state_d  = (LIMIT == SW'(1)) ? HOLD : WAIT;
                    end
                end
                WAIT: begin
                    if (fire || !nonempty) begin
                        state_d  = IDLE;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_inc;
                        if (starve_inc == LIMIT) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (fire || !nonempty) begin
                        state_d  = IDLE;
                        starve_d = '0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    starve_d = '0;
                end
            endcase
        end
    end

    // Hold is taken straight from the state register, so it is glitch-free.
    always_comb begin
        flu_hold_o = (state_q == HOLD);
    end

`ifdef VALU_ISSUE_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fire_cnt_o  <= '0;
            perf_block_cnt_o <= '0;
            perf_hold_cnt_o  <= '0;
        end else begin
            if (fire) begin
                perf_fire_cnt_o <= perf_fire_cnt_o + 32'd1;
            end
            if (nonempty && !fire && !flush_i) begin
                perf_block_cnt_o <= perf_block_cnt_o + 32'd1;
            end
            if (flu_hold_o) begin
                perf_hold_cnt_o <= perf_hold_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
